// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with a registered output, fixed-index or round-robin select; define MUX_BEAT_CNT_EN to add the beat_cnt output
module stream_mux_rr #(
    parameter int DATA_W = 32,
    parameter int N_CH = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic [N_CH-1:0]        in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
`ifdef MUX_BEAT_CNT_EN
    output logic [31:0]            beat_cnt,
`endif
    input  logic                   out_ready
);
    localparam int NP = 1 << SEL_W;
    logic [NP-1:0] vld_x;
    logic [SEL_W-1:0] rr_ptr, rr_gnt, gnt, k;
    logic rr_hit, hit, load_en, xfer;
    // zero-extended so an index >= N_CH reads as "not valid" and never grants
    assign vld_x = NP'(in_valid);
    always_comb begin
        rr_gnt = '0;
        rr_hit = 1'b0;
        k = '0;
        for (int i = 0; i < N_CH; i++) begin
            k = SEL_W'((int'(rr_ptr) + i) % N_CH);
            if (!rr_hit && vld_x[k]) begin
                rr_gnt = k;
                rr_hit = 1'b1;
            end
        end
    end
    assign gnt = mode ? rr_gnt : sel;
    assign hit = mode ? rr_hit : vld_x[sel];
    assign load_en = !out_valid || out_ready;
    assign xfer = load_en && hit;
    assign in_ready = xfer ? N_CH'(1) << gnt : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_ch <= '0;
            rr_ptr <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data <= in_data[int'(gnt)*DATA_W +: DATA_W];
            out_ch <= gnt;
            rr_ptr <= (gnt == SEL_W'(N_CH - 1)) ? '0 : gnt + SEL_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`ifdef MUX_BEAT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) beat_cnt <= '0;
        else if (out_valid && out_ready) beat_cnt <= beat_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: checks a 4-channel and a 3-channel stream_mux_rr against a spec-level model; MUX_BEAT_CNT_EN enables beat_cnt checks
module tb_stream_mux_rr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] vld = '0;
    logic [31:0] dat [4];
    logic [127:0] in_data;
    logic out_ready = 1'b0;
    logic [3:0] rdy4;
    logic [2:0] rdy3;
    logic ov4, ov3;
    logic [31:0] od4, od3;
    logic [1:0] oc4, oc3;
`ifdef MUX_BEAT_CNT_EN
    logic [31:0] bc4, bc3;
`endif
    int total = 0;
    int bad = 0;
    bit mv [2];
    logic [31:0] md [2];
    int mc [2];
    int mp [2];
    logic [31:0] mb [2];

    always #5 clk = ~clk;
    assign in_data = {dat[3], dat[2], dat[1], dat[0]};

    stream_mux_rr #(.DATA_W(32), .N_CH(4)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(vld), .in_data(in_data), .in_ready(rdy4),
        .out_valid(ov4), .out_data(od4), .out_ch(oc4),
`ifdef MUX_BEAT_CNT_EN
        .beat_cnt(bc4),
`endif
        .out_ready(out_ready)
    );

    stream_mux_rr #(.DATA_W(32), .N_CH(3)) u_dut3 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(vld[2:0]), .in_data(in_data[95:0]), .in_ready(rdy3),
        .out_valid(ov3), .out_data(od3), .out_ch(oc3),
`ifdef MUX_BEAT_CNT_EN
        .beat_cnt(bc3),
`endif
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // grant chosen by the selection rules, -1 when nothing may transfer
    function automatic int ref_grant(int n, bit m, int s, logic [3:0] v, int p);
        if (!m) return (s < n && v[s]) ? s : -1;
        for (int i = 0; i < n; i++)
            if (v[(p + i) % n]) return (p + i) % n;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ov4", 32'(ov4), 0);
        check("rst_od4", od4, 0);
        check("rst_oc4", 32'(oc4), 0);
        check("rst_ov3", 32'(ov3), 0);
        check("rst_od3", od3, 0);
        check("rst_oc3", 32'(oc3), 0);
`ifdef MUX_BEAT_CNT_EN
        check("rst_bc4", bc4, 0);
        check("rst_bc3", bc3, 0);
`endif
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mv[d] = 0;
            md[d] = '0;
            mc[d] = 0;
            mp[d] = 0;
            mb[d] = '0;
        end
    endtask

    task automatic step();
        int n, g;
        bit ld;
        logic [3:0] er;
        bit nv [2];
        logic [31:0] nd [2];
        int nc [2];
        int np [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            n = d ? 3 : 4;
            ld = !mv[d] || out_ready;
            g = ref_grant(n, mode, int'(sel), vld & (d ? 4'b0111 : 4'b1111), mp[d]);
            er = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
            check($sformatf("in_ready_n%0d", n), d ? 32'(rdy3) : 32'(rdy4), 32'(er));
            nv[d] = mv[d];
            nd[d] = md[d];
            nc[d] = mc[d];
            np[d] = mp[d];
            if (mv[d] && out_ready) begin
                nv[d] = 0;
                mb[d] = mb[d] + 1;
            end
            if (ld && g >= 0) begin
                nv[d] = 1;
                nd[d] = dat[g];
                nc[d] = g;
                np[d] = (g + 1) % n;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            mv[d] = nv[d];
            md[d] = nd[d];
            mc[d] = nc[d];
            mp[d] = np[d];
        end
        check("out_valid_n4", 32'(ov4), 32'(mv[0]));
        check("out_data_n4", od4, md[0]);
        check("out_ch_n4", 32'(oc4), mc[0]);
        check("out_valid_n3", 32'(ov3), 32'(mv[1]));
        check("out_data_n3", od3, md[1]);
        check("out_ch_n3", 32'(oc3), mc[1]);
`ifdef MUX_BEAT_CNT_EN
        check("beat_cnt_n4", bc4, mb[0]);
        check("beat_cnt_n3", bc3, mb[1]);
`endif
    endtask

    initial begin
        int seq_a [5] = '{0, 1, 2, 3, 0};
        int seq_b [4] = '{0, 2, 3, 0};
        for (int k = 0; k < 4; k++) dat[k] = 32'h100 + k;
        #2;
        do_reset();
        // fixed select of channel 2, then async reset while a beat is held
        mode = 1'b0; sel = 2'd2; vld = 4'hF; out_ready = 1'b1;
        #1;
        check("fix_rdy", 32'(rdy4), 32'b0100);
        step();
        check("fix_data", od4, 32'h102);
        check("fix_ch", 32'(oc4), 2);
        check("held_valid", 32'(ov4), 1);
        do_reset();
        // round-robin with all channels valid, then with channel 1 idle
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_seq_all", 32'(oc4), seq_a[i]);
        end
        do_reset();
        vld = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_seq_skip1", 32'(oc4), seq_b[i]);
        end
        // backpressure; sel moves during the stall but the held beat must not
        do_reset();
        mode = 1'b0; sel = 2'd1; vld = 4'hF;
        step();
        out_ready = 1'b0; sel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_data", od4, 32'h101);
            check("stall_rdy", 32'(rdy4), 0);
        end
        out_ready = 1'b1;
        step();
        check("release_valid", 32'(ov4), 1);
        check("release_data", od4, 32'h103);
        check("release_ch", 32'(oc4), 3);
        // out-of-range index on the 3-channel build, then pointer wrap from channel 2
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            check("sel3_rdy", 32'(rdy3), 0);
            check("sel3_valid", 32'(ov3), 0);
        end
        mode = 1'b1; vld = 4'b0100;
        step();
        check("wrap_ch2", 32'(oc3), 2);
        vld = 4'b0111;
        step();
        check("wrap_ch0", 32'(oc3), 0);
`ifdef MUX_BEAT_CNT_EN
        do_reset();
        mode = 1'b0; sel = 2'd0; vld = 4'hF;
        for (int i = 0; i < 11; i++) step();
        check("beat_cnt_10", bc4, 10);
        force u_dut.beat_cnt = 32'hFFFF_FFFE;
        #1;
        release u_dut.beat_cnt;
        mb[0] = 32'hFFFF_FFFE;
        step();
        step();
        check("beat_cnt_wrap", bc4, 0);
`endif
        // random traffic with occasional mid-stream reset
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mode = 1'($urandom);
            sel = 2'($urandom);
            vld = 4'($urandom);
            for (int k = 0; k < 4; k++) dat[k] = $urandom;
            out_ready = ($urandom % 4) != 0;
            if ($urandom % 64 == 0) do_reset();
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
